ntt_bu_pipe: RTL
================

Name: ntt_bu_pipe

Overview:
- Parametrised, fully pipelined radix-R NTT butterfly unit; successor to the fixed radix-16 combinational-interface BU.
- Accepts one R-point vector per beat and applies per-lane pre-twiddles.
- Performs a size-R cyclic NTT over Z_q as log2(R) radix-2 DIF stages.
- Uses a valid/ready handshake with global stall; sits between the NTT data-memory read path and the write-back path.

Parameters:
- DW, 17, data/modulus width in bits (q ≤ 2^DW − 1).
- R, 16, radix; power of two, 2..64.
- LOG2R, $clog2(R), number of butterfly stages; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- x  in  R*DW  input lanes; lane i = x[i*DW +: DW]; each lane < modulus.
- tw  in  R*DW  pre-twiddle per lane, same packing; each < modulus.
- bypass_tw  in  1  1 = treat all pre-twiddles as 1; sampled with the beat.
- omega_pow  in  (R/2)*DW  omega^j for j = 0..R/2−1, with omega a primitive R-th root mod q.
- modulus  in  DW  q; must be stable while busy = 1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y  out  R*DW  result lanes, each < modulus.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (rst = 0, async): all stage valid bits clear, all data registers 0, y = 0, out_valid = 0, busy = 0.
- in_ready = 1 during reset release.
- Pipeline enable: en = !out_valid || out_ready. One global stall; every stage advances only when en = 1.
- in_ready = en. A beat transfers when in_valid && in_ready.
- Stage P (1 cycle): a_i = bypass_tw ? x_i : (x_i*tw_i) mod q.
  - Product is full 2*DW bits, reduced to < q before registering.
- DIF stage s, for s = 0..LOG2R−1; each stage is 2 register cycles:
  - Cycle A: with h = R>>(s+1), for each pair (j, j+h) at offset t within its block:
    - sum = (a_j + a_{j+h}) mod q, using DW+1-bit add and conditional subtract.
    - dif = (a_j − a_{j+h}) mod q, adding q on borrow.
  - Cycle B: a'_j = sum; a'_{j+h} = (dif * omega_pow[t<<s]) mod q.
- Latency: LAT = 1 + 2*LOG2R cycles from input transfer to out_valid with no stall; R = 16 gives 9.
- Throughput: one beat per cycle while out_ready = 1.
- Output order (macro off): lane p holds natural-order result Y[bitrev_LOG2R(p)].
  - Natural-order result: Y[k] = Σ_i a_i·omega^(i·k) mod q.
- out_valid holds and y is stable while out_ready = 0. No beat is dropped or duplicated.
- Simultaneous in_valid with a full pipeline and out_ready = 1: both transfers occur in the same cycle.
- Reset asserted mid-operation: all in-flight beats are discarded; no partial output appears after release.
- Inputs ≥ q, or modulus changed while busy: results are undefined, but handshake and valid timing are unaffected.

Optional Feature:
- Macro: NTT_BU_BITREV_OUT_EN.
- When defined: a combinational lane permutation is applied on the output register path, so lane k = Y[k] (natural order). LAT is unchanged.
- When undefined: output is in bit-reversed order as above, and no permutation logic is built.

Test Plan:
- Sum/impulse: R = 16, q = 65537, omega = 4 (omega_pow = 1, 4, 16, 64, 256, 1024, 4096, 16384), bypass_tw = 1.
  - All x = 1 -> lane 0 = 16, lanes 1..15 = 0, in either output order.
  - x0 = 5, others 0 -> all lanes = 5.
- Bit-reversal: x1 = 1, others 0, bypass_tw = 1.
  - Macro off -> lane 1 = 65536 (4^8), lane 8 = 4, lane 15 = 4^15 mod q.
  - Macro on -> lane k = 4^k mod q.
- Pre-twiddle: x_i = 1, tw_i = i+1, bypass_tw = 0 -> lane 0 = 136; remaining lanes match the golden model for every lane.
- Back-to-back with stall:
  - 20 consecutive beats; out_ready low at cycles 12–16 -> in_ready falls in the same cycle.
  - Out_valid beats arrive in order, none lost; first out_valid 9 cycles after first transfer.
- Reset mid-stream: assert rst = 0 with 5 beats in flight -> out_valid = 0, y = 0, busy = 0 immediately.
  - After release, one new beat -> exactly one output, at cycle 9.
- Random regression: 1000 random beats, R ∈ {2, 4, 16}, random out_ready -> all outputs match the reference model, all lanes < q.

Source files
------------

// File: rtl/ntt_bu_pipe.sv
// rtl/ntt_bu_pipe.sv - pipelined radix-R NTT butterfly unit with per-lane pre-twiddle; NTT_BU_BITREV_OUT_EN selects natural-order output lanes
module ntt_bu_pipe #(
    parameter int DW    = 17,
    parameter int R     = 16,
    parameter int LOG2R = $clog2(R)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [R*DW-1:0]       x,
    input  logic [R*DW-1:0]       tw,
    input  logic                  bypass_tw,
    input  logic [(R/2)*DW-1:0]   omega_pow,
    input  logic [DW-1:0]         modulus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [R*DW-1:0]       y,
    output logic                  busy
);

    // Register slot 0 is the pre-twiddle stage; slots 2s+1 / 2s+2 are the
    // add/sub and twiddle-multiply halves of DIF stage s. The last slot is y.
    localparam int NSTG = 1 + 2*LOG2R;
    localparam int HALF = R/2;

    // (a + b) mod q for a, b < q
    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[DW-1:0];
    endfunction

    // (a - b) mod q for a, b < q; a borrow shows up in the extra top bit
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DW]) d = d + {1'b0, q};
        return d[DW-1:0];
    endfunction

    // (a * b) mod q: full 2*DW-bit product, reduced by restoring shift-subtract
    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        logic [2*DW-1:0] prod;
        logic [DW:0]     rem;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        rem  = '0;
        for (int i = 2*DW-1; i >= 0; i--) begin
            rem = {rem[DW-1:0], prod[i]};
            if (rem >= {1'b0, q}) rem = rem - {1'b0, q};
        end
        return rem[DW-1:0];
    endfunction

`ifdef NTT_BU_BITREV_OUT_EN
    // LOG2R-bit reversal of a lane index
    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2R; b++) begin
            if (((v >> b) & 1) != 0) r = r | (1 << (LOG2R-1-b));
        end
        return r;
    endfunction
`endif

    logic [NSTG-1:0] vld_q;
    logic [NSTG-1:0] vld_d;
    logic [DW-1:0]   pipe_q [NSTG][R];
    logic [DW-1:0]   pipe_d [NSTG][R];
    logic            en;

    // One global stall: everything moves only when the output slot can drain
    assign en        = !vld_q[NSTG-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[NSTG-1];
    assign busy      = |vld_q;

    // Next-state datapath for every pipeline slot
    always_comb begin
        int h;
        int t;
        int j;
        h = 1;
        t = 0;
        j = 0;
        vld_d = {vld_q[NSTG-2:0], in_valid};
        for (int s = 0; s < NSTG; s++) begin
            for (int i = 0; i < R; i++) pipe_d[s][i] = '0;
        end
        for (int i = 0; i < R; i++) begin
            pipe_d[0][i] = bypass_tw ? x[i*DW +: DW]
                                     : mod_mul(x[i*DW +: DW], tw[i*DW +: DW], modulus);
        end
        for (int s = 0; s < LOG2R; s++) begin
            for (int k = 0; k < HALF; k++) begin
                h = R >> (s+1);
                t = k % h;
                j = (k / h) * 2 * h + t;
                pipe_d[2*s+1][j]   = mod_add(pipe_q[2*s][j], pipe_q[2*s][j+h], modulus);
                pipe_d[2*s+1][j+h] = mod_sub(pipe_q[2*s][j], pipe_q[2*s][j+h], modulus);
                pipe_d[2*s+2][j]   = pipe_q[2*s+1][j];
                pipe_d[2*s+2][j+h] = mod_mul(pipe_q[2*s+1][j+h],
                                             omega_pow[(t << s)*DW +: DW], modulus);
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                for (int i = 0; i < R; i++) pipe_q[s][i] <= '0;
            end
        end else if (en) begin
            vld_q <= vld_d;
            for (int s = 0; s < NSTG; s++) begin
                for (int i = 0; i < R; i++) pipe_q[s][i] <= pipe_d[s][i];
            end
        end
    end

    // Output lane packing; the optional permutation restores natural order
    always_comb begin
        y = '0;
        for (int p = 0; p < R; p++) begin
`ifdef NTT_BU_BITREV_OUT_EN
            y[p*DW +: DW] = pipe_q[NSTG-1][bitrev(p)];
`else
            y[p*DW +: DW] = pipe_q[NSTG-1][p];
`endif
        end
    end

endmodule
